// File: rtl/lcd_ctrl_gen.sv
// lcd_ctrl_gen: loads a 2^ROW_BITS x 2^COL_BITS image from IROM into a buffer,
// applies single-cycle 2x2 window commands, and streams the buffer to IRAM.
module lcd_ctrl_gen #(
    parameter int unsigned DW       = 8,
    parameter int unsigned ROW_BITS = 3,
    parameter int unsigned COL_BITS = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   cmd,
    input  logic                         cmd_valid,
    input  logic [DW-1:0]                IROM_Q,
    output logic                         IROM_rd,
    output logic [ROW_BITS+COL_BITS-1:0] IROM_A,
    output logic                         IRAM_valid,
    output logic [DW-1:0]                IRAM_D,
    output logic [ROW_BITS+COL_BITS-1:0] IRAM_A,
    output logic                         busy,
    output logic                         done
);
    localparam int unsigned AW = ROW_BITS + COL_BITS;
    localparam int unsigned N  = 1 << AW;
    localparam int unsigned CW = AW + 2;
    localparam int unsigned SW = DW + 2;

    localparam logic [ROW_BITS-1:0] ROW_MID = ROW_BITS'(1 << (ROW_BITS - 1));
    localparam logic [COL_BITS-1:0] COL_MID = COL_BITS'(1 << (COL_BITS - 1));
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'((1 << ROW_BITS) - 1);
    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'((1 << COL_BITS) - 1);
    localparam logic [CW-1:0]       CNT_N   = CW'(N);
    localparam logic [CW-1:0]       CNT_END = CW'(N + 1);

    localparam logic [3:0] CMD_WRITE  = 4'd0;
    localparam logic [3:0] CMD_UP     = 4'd1;
    localparam logic [3:0] CMD_DOWN   = 4'd2;
    localparam logic [3:0] CMD_LEFT   = 4'd3;
    localparam logic [3:0] CMD_RIGHT  = 4'd4;
    localparam logic [3:0] CMD_MAX    = 4'd5;
    localparam logic [3:0] CMD_MIN    = 4'd6;
    localparam logic [3:0] CMD_AVG    = 4'd7;
    localparam logic [3:0] CMD_CCW    = 4'd8;
    localparam logic [3:0] CMD_CW     = 4'd9;
    localparam logic [3:0] CMD_MIRX   = 4'd10;
    localparam logic [3:0] CMD_MIRY   = 4'd11;
    localparam logic [3:0] CMD_CENTER = 4'd12;
    localparam logic [3:0] CMD_RELOAD = 4'd13;

    typedef enum logic [2:0] {FETCH, WAIT_CMD, PROCESS, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic                rom_rd_q, rom_rd_d;
    logic [AW-1:0]       rom_a_q, rom_a_d;
    logic                ram_valid_q, ram_valid_d;
    logic [AW-1:0]       ram_a_q, ram_a_d;
    logic [DW-1:0]       ram_d_q, ram_d_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DW-1:0]       mem_q [N];
    logic                fetch_we;
    logic                win_we;
    logic [AW-1:0]       cnt_a;
    logic [AW-1:0]       fetch_a;

    assign cnt_a   = cnt_q[AW-1:0];
    assign fetch_a = AW'(cnt_q - CW'(2));

    // Window addressing: anchor is the lower-right pixel, always >= (1,1).
    logic [ROW_BITS-1:0] row_up;
    logic [COL_BITS-1:0] col_lf;
    logic [AW-1:0]       ul_a, ur_a, ll_a, lr_a;
    logic [DW-1:0]       ul_v, ur_v, ll_v, lr_v;
    logic [DW-1:0]       ul_n, ur_n, ll_n, lr_n;
    logic [DW-1:0]       top_max, bot_max, win_max;
    logic [DW-1:0]       top_min, bot_min, win_min;
    logic [SW-1:0]       win_sum;

    assign row_up  = row_q - ROW_BITS'(1);
    assign col_lf  = col_q - COL_BITS'(1);
    assign ul_a    = {row_up, col_lf};
    assign ur_a    = {row_up, col_q};
    assign ll_a    = {row_q, col_lf};
    assign lr_a    = {row_q, col_q};
    assign ul_v    = mem_q[ul_a];
    assign ur_v    = mem_q[ur_a];
    assign ll_v    = mem_q[ll_a];
    assign lr_v    = mem_q[lr_a];
    assign top_max = (ul_v > ur_v) ? ul_v : ur_v;
    assign bot_max = (ll_v > lr_v) ? ll_v : lr_v;
    assign win_max = (top_max > bot_max) ? top_max : bot_max;
    assign top_min = (ul_v < ur_v) ? ul_v : ur_v;
    assign bot_min = (ll_v < lr_v) ? ll_v : lr_v;
    assign win_min = (top_min < bot_min) ? top_min : bot_min;
    assign win_sum = SW'(ul_v) + SW'(ur_v) + SW'(ll_v) + SW'(lr_v);

    // New window contents for the latched command (all reads pre-update).
    always_comb begin
        ul_n = ul_v;
        ur_n = ur_v;
        ll_n = ll_v;
        lr_n = lr_v;
        case (cmd_q)
            CMD_MAX:  begin ul_n = win_max; ur_n = win_max; ll_n = win_max; lr_n = win_max; end
            CMD_MIN:  begin ul_n = win_min; ur_n = win_min; ll_n = win_min; lr_n = win_min; end
            CMD_AVG:  begin
                ul_n = win_sum[SW-1:2];
                ur_n = win_sum[SW-1:2];
                ll_n = win_sum[SW-1:2];
                lr_n = win_sum[SW-1:2];
            end
            CMD_CCW:  begin ul_n = ur_v; ur_n = lr_v; lr_n = ll_v; ll_n = ul_v; end
            CMD_CW:   begin ul_n = ll_v; ur_n = ul_v; lr_n = ur_v; ll_n = lr_v; end
            CMD_MIRX: begin ul_n = ll_v; ll_n = ul_v; ur_n = lr_v; lr_n = ur_v; end
            CMD_MIRY: begin ul_n = ur_v; ur_n = ul_v; ll_n = lr_v; lr_n = ll_v; end
            default:  ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        row_d       = row_q;
        col_d       = col_q;
        rom_rd_d    = 1'b0;
        rom_a_d     = rom_a_q;
        ram_valid_d = 1'b0;
        ram_a_d     = ram_a_q;
        ram_d_d     = ram_d_q;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        fetch_we    = 1'b0;
        win_we      = 1'b0;
        case (state_q)
            // Count k issues address k; ROM data for k-2 lands on count k.
            FETCH: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q < CNT_N) begin
                    rom_rd_d = 1'b1;
                    rom_a_d  = cnt_a;
                end
                if (cnt_q >= CW'(2)) fetch_we = 1'b1;
                if (cnt_q == CNT_END) begin
                    state_d = WAIT_CMD;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            WAIT_CMD: begin
                busy_d = 1'b0;
                if (cmd_valid) begin
                    busy_d = 1'b1;
                    case (cmd)
                        CMD_WRITE: begin
                            state_d     = WRITE;
                            ram_valid_d = 1'b1;
                            ram_a_d     = '0;
                            ram_d_d     = mem_q[{AW{1'b0}}];
                            cnt_d       = CW'(1);
                        end
                        CMD_RELOAD: begin
                            state_d  = FETCH;
                            rom_rd_d = 1'b1;
                            rom_a_d  = '0;
                            cnt_d    = CW'(1);
                            row_d    = ROW_MID;
                            col_d    = COL_MID;
                        end
                        default: begin
                            state_d = PROCESS;
                            cmd_d   = cmd;
                        end
                    endcase
                end
            end
            PROCESS: begin
                state_d = WAIT_CMD;
                busy_d  = 1'b0;
                win_we  = (cmd_q >= CMD_MAX) && (cmd_q <= CMD_MIRY);
                case (cmd_q)
                    CMD_UP:     if (row_q > ROW_BITS'(1)) row_d = row_q - ROW_BITS'(1);
                    CMD_DOWN:   if (row_q < ROW_MAX) row_d = row_q + ROW_BITS'(1);
                    CMD_LEFT:   if (col_q > COL_BITS'(1)) col_d = col_q - COL_BITS'(1);
                    CMD_RIGHT:  if (col_q < COL_MAX) col_d = col_q + COL_BITS'(1);
                    CMD_CENTER: begin row_d = ROW_MID; col_d = COL_MID; end
                    default:    ;
                endcase
            end
            WRITE: begin
                if (cnt_q < CNT_N) begin
                    ram_valid_d = 1'b1;
                    ram_a_d     = cnt_a;
                    ram_d_d     = mem_q[cnt_a];
                    cnt_d       = cnt_q + CW'(1);
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = WAIT_CMD;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = FETCH;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            cnt_q       <= '0;
            cmd_q       <= '0;
            row_q       <= ROW_MID;
            col_q       <= COL_MID;
            rom_rd_q    <= 1'b0;
            rom_a_q     <= '0;
            ram_valid_q <= 1'b0;
            ram_a_q     <= '0;
            ram_d_q     <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rom_rd_q    <= rom_rd_d;
            rom_a_q     <= rom_a_d;
            ram_valid_q <= ram_valid_d;
            ram_a_q     <= ram_a_d;
            ram_d_q     <= ram_d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Image buffer has no reset; the four window writes never alias.
    always_ff @(posedge clk) begin
        if (fetch_we) mem_q[fetch_a] <= IROM_Q;
        if (win_we) begin
            mem_q[ul_a] <= ul_n;
            mem_q[ur_a] <= ur_n;
            mem_q[ll_a] <= ll_n;
            mem_q[lr_a] <= lr_n;
        end
    end

    assign IROM_rd    = rom_rd_q;
    assign IROM_A     = rom_a_q;
    assign IRAM_valid = ram_valid_q;
    assign IRAM_A     = ram_a_q;
    assign IRAM_D     = ram_d_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Bench for lcd_ctrl_gen: an 8x8 and a 4x16 instance run the same command
// stream in lockstep against an array-based image/anchor model.
module tb_lcd_ctrl_gen;
    localparam int NPIX = 64;

    logic       clk;
    logic       reset;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [7:0] rom_q [2];
    logic       rom_rd [2];
    logic [5:0] rom_a [2];
    logic       ram_v [2];
    logic [7:0] ram_d [2];
    logic [5:0] ram_a [2];
    logic       busy [2];
    logic       done [2];

    lcd_ctrl_gen u_sq (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_Q(rom_q[0]), .IROM_rd(rom_rd[0]), .IROM_A(rom_a[0]),
        .IRAM_valid(ram_v[0]), .IRAM_D(ram_d[0]), .IRAM_A(ram_a[0]),
        .busy(busy[0]), .done(done[0])
    );

    lcd_ctrl_gen #(.DW(8), .ROW_BITS(2), .COL_BITS(4)) u_wide (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_Q(rom_q[1]), .IROM_rd(rom_rd[1]), .IROM_A(rom_a[1]),
        .IRAM_valid(ram_v[1]), .IRAM_D(ram_d[1]), .IRAM_A(ram_a[1]),
        .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROMs, one per instance.
    logic [7:0] rom [2][NPIX];
    always @(posedge clk) begin
        if (rom_rd[0] === 1'b1) rom_q[0] <= rom[0][rom_a[0]];
        if (rom_rd[1] === 1'b1) rom_q[1] <= rom[1][rom_a[1]];
    end

    int done_cnt = 0;
    always @(negedge clk) if (done[0] === 1'b1) done_cnt <= done_cnt + 1;

    int n_checks;
    int n_fail;
    int img [2][NPIX];
    int got [2][NPIX];
    int ar [2];
    int ac [2];
    int hgt [2];
    int wid [2];

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] ul, ur, ll, lr;
        logic [7:0] eul, eur, ell, elr;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic recentre(input int d);
        ar[d] = hgt[d] / 2;
        ac[d] = wid[d] / 2;
    endtask

    task automatic model_reload();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NPIX; k++) img[d][k] = int'(rom[d][k]);
            recentre(d);
        end
    endtask

    // Reference behaviour of one window/anchor command on both images.
    task automatic model_cmd(input int c);
        for (int d = 0; d < 2; d++) begin
            int ul, ur, ll, lr, a, b, e, f, mx, mn;
            ul = (ar[d] - 1) * wid[d] + ac[d] - 1;
            ur = ul + 1;
            ll = ul + wid[d];
            lr = ll + 1;
            a = img[d][ul]; b = img[d][ur]; e = img[d][ll]; f = img[d][lr];
            mx = a; if (b > mx) mx = b; if (e > mx) mx = e; if (f > mx) mx = f;
            mn = a; if (b < mn) mn = b; if (e < mn) mn = e; if (f < mn) mn = f;
            case (c)
                1: if (ar[d] > 1) ar[d]--;
                2: if (ar[d] < hgt[d] - 1) ar[d]++;
                3: if (ac[d] > 1) ac[d]--;
                4: if (ac[d] < wid[d] - 1) ac[d]++;
                5: begin img[d][ul] = mx; img[d][ur] = mx; img[d][ll] = mx; img[d][lr] = mx; end
                6: begin img[d][ul] = mn; img[d][ur] = mn; img[d][ll] = mn; img[d][lr] = mn; end
                7: begin
                    img[d][ul] = (a + b + e + f) / 4; img[d][ur] = img[d][ul];
                    img[d][ll] = img[d][ul];          img[d][lr] = img[d][ul];
                end
                8:  begin img[d][ul] = b; img[d][ur] = f; img[d][lr] = e; img[d][ll] = a; end
                9:  begin img[d][ul] = e; img[d][ur] = a; img[d][lr] = b; img[d][ll] = f; end
                10: begin img[d][ul] = e; img[d][ll] = a; img[d][ur] = f; img[d][lr] = b; end
                11: begin img[d][ul] = b; img[d][ur] = a; img[d][ll] = f; img[d][lr] = e; end
                12: recentre(d);
                default: ;
            endcase
        end
    endtask

    // Entered on the first FETCH cycle; returns on the first idle cycle.
    task automatic check_fetch();
        for (int k = 0; k < NPIX; k++) begin
            for (int d = 0; d < 2; d++) begin
                chk("fetch_rd", d, 32'(rom_rd[d]), 1);
                chk("fetch_addr", d, 32'(rom_a[d]), k);
                chk("fetch_busy", d, 32'(busy[d]), 1);
            end
            cmd = 4'($urandom);
            cmd_valid = 1'($urandom);
            step();
        end
        cmd_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("fetch_rd_end", d, 32'(rom_rd[d]), 0);
            chk("fetch_busy_end", d, 32'(busy[d]), 1);
        end
        step();
        for (int d = 0; d < 2; d++) chk("fetch_ready", d, 32'(busy[d]), 0);
    endtask

    task automatic send(input logic [3:0] c);
        int guard;
        guard = 0;
        while (busy[0] !== 1'b0 && guard < 400) begin
            step();
            guard++;
        end
        chk("idle_before_cmd", 0, 32'(busy[0]), 0);
        cmd = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int d = 0; d < 2; d++) chk("busy_after_accept", d, 32'(busy[d]), 1);
        if (c == 4'd13) begin
            model_reload();
            check_fetch();
        end else if (c != 4'd0) begin
            model_cmd(int'(c));
            cmd = 4'($urandom);
            cmd_valid = 1'($urandom);
            step();
            cmd_valid = 1'b0;
            for (int d = 0; d < 2; d++) chk("busy_after_process", d, 32'(busy[d]), 0);
        end
    endtask

    task automatic write_out();
        send(4'd0);
        for (int k = 0; k < NPIX; k++) begin
            for (int d = 0; d < 2; d++) begin
                chk("wr_valid", d, 32'(ram_v[d]), 1);
                chk("wr_addr", d, 32'(ram_a[d]), k);
                chk("wr_data", d, 32'(ram_d[d]), img[d][k]);
                got[d][k] = int'(ram_d[d]);
            end
            cmd = 4'($urandom);
            cmd_valid = 1'($urandom);
            step();
        end
        cmd_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("end_valid_low", d, 32'(ram_v[d]), 0);
            chk("done_pulse", d, 32'(done[d]), 1);
            chk("done_busy", d, 32'(busy[d]), 1);
        end
        step();
        for (int d = 0; d < 2; d++) begin
            chk("done_cleared", d, 32'(done[d]), 0);
            chk("idle_after_done", d, 32'(busy[d]), 0);
        end
    endtask

    task automatic fill_rom_random();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < NPIX; k++) rom[d][k] = 8'($urandom);
    endtask

    initial begin
        int ctr, dc, r;
        logic [3:0] c;
        n_checks = 0;
        n_fail   = 0;
        hgt[0] = 8; wid[0] = 8;
        hgt[1] = 4; wid[1] = 16;

        vecs[0]  = {4'd7,  8'd10,  8'd20,  8'd30,  8'd41,  8'd25,  8'd25,  8'd25,  8'd25};
        vecs[1]  = {4'd5,  8'd10,  8'd20,  8'd30,  8'd41,  8'd41,  8'd41,  8'd41,  8'd41};
        vecs[2]  = {4'd6,  8'd10,  8'd20,  8'd30,  8'd41,  8'd10,  8'd10,  8'd10,  8'd10};
        vecs[3]  = {4'd8,  8'd10,  8'd20,  8'd30,  8'd41,  8'd20,  8'd41,  8'd10,  8'd30};
        vecs[4]  = {4'd9,  8'd10,  8'd20,  8'd30,  8'd41,  8'd30,  8'd10,  8'd41,  8'd20};
        vecs[5]  = {4'd10, 8'd10,  8'd20,  8'd30,  8'd41,  8'd30,  8'd41,  8'd10,  8'd20};
        vecs[6]  = {4'd11, 8'd10,  8'd20,  8'd30,  8'd41,  8'd20,  8'd10,  8'd41,  8'd30};
        vecs[7]  = {4'd12, 8'd10,  8'd20,  8'd30,  8'd41,  8'd10,  8'd20,  8'd30,  8'd41};
        vecs[8]  = {4'd15, 8'd10,  8'd20,  8'd30,  8'd41,  8'd10,  8'd20,  8'd30,  8'd41};
        vecs[9]  = {4'd7,  8'd255, 8'd255, 8'd255, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254};
        vecs[10] = {4'd7,  8'd1,   8'd2,   8'd2,   8'd2,   8'd1,   8'd1,   8'd1,   8'd1};

        reset = 1'b1;
        cmd = 4'd0;
        cmd_valid = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < NPIX; k++) rom[d][k] = 8'(k);

        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_irom_rd", d, 32'(rom_rd[d]), 0);
            chk("rst_irom_a", d, 32'(rom_a[d]), 0);
            chk("rst_iram_valid", d, 32'(ram_v[d]), 0);
            chk("rst_iram_a", d, 32'(ram_a[d]), 0);
            chk("rst_iram_d", d, 32'(ram_d[d]), 0);
            chk("rst_busy", d, 32'(busy[d]), 1);
            chk("rst_done", d, 32'(done[d]), 0);
        end
        step();
        step();
        reset = 1'b1;
        step();
        model_reload();
        check_fetch();

        // Straight write-out of the identity image.
        write_out();

        // Anchor saturates at top-left; CW rotate lands on the corner window.
        repeat (5) send(4'd1);
        repeat (8) send(4'd3);
        send(4'd9);
        write_out();
        chk("cw_corner_0", 0, 32'(got[0][0]), 8);
        chk("cw_corner_1", 0, 32'(got[0][1]), 0);
        chk("cw_corner_8", 0, 32'(got[0][8]), 9);
        chk("cw_corner_9", 0, 32'(got[0][9]), 1);
        chk("cw_corner_0", 1, 32'(got[1][0]), 16);
        chk("cw_corner_16", 1, 32'(got[1][16]), 17);

        // Anchor saturates at the right edge; min hits the last two columns.
        repeat (20) send(4'd4);
        send(4'd6);
        write_out();
        chk("min_14", 1, 32'(got[1][14]), 14);
        chk("min_15", 1, 32'(got[1][15]), 14);
        chk("min_30", 1, 32'(got[1][30]), 14);
        chk("min_31", 1, 32'(got[1][31]), 14);
        chk("min_keep_29", 1, 32'(got[1][29]), 29);
        chk("min_6", 0, 32'(got[0][6]), 6);
        chk("min_15", 0, 32'(got[0][15]), 6);

        // Reload discards edits and re-centres the anchor.
        send(4'd8);
        fill_rom_random();
        send(4'd13);
        write_out();
        for (int k = 0; k < NPIX; k += 9) chk("reload_image", 0, 32'(got[0][k]), 32'(rom[0][k]));
        send(4'd7);
        write_out();

        // Table of window operations at the centre anchor.
        for (int i = 0; i < 11; i++) begin
            fill_rom_random();
            for (int d = 0; d < 2; d++) begin
                int ul;
                ul = (hgt[d] / 2 - 1) * wid[d] + wid[d] / 2 - 1;
                rom[d][ul]              = vecs[i].ul;
                rom[d][ul + 1]          = vecs[i].ur;
                rom[d][ul + wid[d]]     = vecs[i].ll;
                rom[d][ul + wid[d] + 1] = vecs[i].lr;
            end
            send(4'd13);
            send(vecs[i].op);
            write_out();
            for (int d = 0; d < 2; d++) begin
                int ul;
                ul = (hgt[d] / 2 - 1) * wid[d] + wid[d] / 2 - 1;
                chk("vec_ul", d, 32'(got[d][ul]), 32'(vecs[i].eul));
                chk("vec_ur", d, 32'(got[d][ul + 1]), 32'(vecs[i].eur));
                chk("vec_ll", d, 32'(got[d][ul + wid[d]]), 32'(vecs[i].ell));
                chk("vec_lr", d, 32'(got[d][ul + wid[d] + 1]), 32'(vecs[i].elr));
            end
        end

        // Random command stream against the model.
        for (ctr = 0; ctr < 150; ctr++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                write_out();
            end else if (r == 1) begin
                fill_rom_random();
                send(4'd13);
            end else begin
                c = 4'($urandom_range(1, 14));
                if (c == 4'd13) c = 4'd15;
                send(c);
            end
        end
        write_out();

        // Reset in the middle of a write-out.
        send(4'd0);
        repeat (20) step();
        dc = done_cnt;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("abort_valid", d, 32'(ram_v[d]), 0);
            chk("abort_iram_a", d, 32'(ram_a[d]), 0);
            chk("abort_busy", d, 32'(busy[d]), 1);
            chk("abort_done", d, 32'(done[d]), 0);
            chk("abort_rd", d, 32'(rom_rd[d]), 0);
        end
        step();
        step();
        reset = 1'b1;
        step();
        model_reload();
        check_fetch();
        chk("abort_no_done", 0, 32'(done_cnt), 32'(dc));
        write_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
